// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle processor control path:
// FSM state encoding, opcode/funct field values and ALU operation codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    // Instruction opcodes (bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (bits [5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation select
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // States that sit waiting on mem_ready and are guarded by the timeout
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps an R-type funct field onto the ALU operation select and flags
// function codes the datapath does not implement.
module alu_decoder (
    input  logic [5:0] funct,
    output logic [3:0] alu_ctl,
    output logic       illegal
);
    import ctrl_pkg::*;

    // Pure table lookup; unknown codes select AND and raise illegal
    always_comb begin
        alu_ctl = ALU_AND;
        illegal = 1'b0;
        case (funct)
            FN_AND:  alu_ctl = ALU_AND;
            FN_OR:   alu_ctl = ALU_OR;
            FN_ADD:  alu_ctl = ALU_ADD;
            FN_SUB:  alu_ctl = ALU_SUB;
            FN_SLT:  alu_ctl = ALU_SLT;
            default: begin
                alu_ctl = ALU_AND;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath. Datapath selects
// decode from the state register; IRWrite/pc_en are additionally qualified
// by mem_ready (FETCH) and zero (BRANCH) so they fire in the completing cycle.
// A wait counter traps on memory that never answers; trap is sticky until rst.
module multicycle_control #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [3:0]       ALUcontrol,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic             IorD,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             Branch,
    output logic             pc_en,
    output logic             trap,
    output logic [CNT_W-1:0] instr_count
);
    import ctrl_pkg::*;

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    state_t             state_r;
    state_t             next_state_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [CNT_W-1:0]   instr_count_r;
    logic               trap_r;
    logic               retire_s;
    logic               wait_last_s;
    logic [3:0]         dec_alu_s;
    logic               dec_illegal_s;

    logic mem_read_s, mem_write_s, ir_write_s, reg_write_s, pc_en_s;

    alu_decoder u_alu_decoder (
        .funct   (funct),
        .alu_ctl (dec_alu_s),
        .illegal (dec_illegal_s)
    );

    // Last permitted waiting cycle: one more miss reaches WAIT_MAX
    assign wait_last_s = (wait_cnt_r == WAIT_W'(WAIT_MAX - 1));

    // Next-state selection and retirement detection
    always_comb begin
        next_state_s = state_r;
        retire_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (mem_ready)        next_state_s = S_DECODE;
                else if (wait_last_s) next_state_s = S_TRAP;
                else                  next_state_s = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_RTYPE:     next_state_s = S_EXEC;
                    OP_BEQ:       next_state_s = S_BRANCH;
                    OP_J:         next_state_s = S_JUMP;
                    default:      next_state_s = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)      next_state_s = S_MEMRD;
                else if (opcode == OP_SW) next_state_s = S_MEMWR;
                else                      next_state_s = S_TRAP;
            end
            S_MEMRD: begin
                if (mem_ready)        next_state_s = S_MEMWB;
                else if (wait_last_s) next_state_s = S_TRAP;
                else                  next_state_s = S_MEMRD;
            end
            S_MEMWB: begin
                next_state_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    next_state_s = S_FETCH;
                    retire_s     = 1'b1;
                end else if (wait_last_s) begin
                    next_state_s = S_TRAP;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_EXEC: begin
                if (dec_illegal_s) next_state_s = S_TRAP;
                else               next_state_s = S_ALUWB;
            end
            S_ALUWB, S_BRANCH, S_JUMP: begin
                next_state_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_TRAP:  next_state_s = S_TRAP;
            default: next_state_s = S_TRAP;
        endcase
    end

    // State, wait counter, retired count and sticky trap flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_FETCH;
            wait_cnt_r    <= '0;
            instr_count_r <= '0;
            trap_r        <= 1'b0;
        end else begin
            state_r <= next_state_s;
            trap_r  <= (next_state_s == S_TRAP);
            if (retire_s) begin
                instr_count_r <= instr_count_r + CNT_W'(1);
            end
            // Any state change restarts the count for the state being entered
            if (next_state_s != state_r) begin
                wait_cnt_r <= '0;
            end else if (is_wait_state(state_r) && !mem_ready) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end
        end
    end

    // Per-state control decode; anything not named for a state stays 0
    always_comb begin
        ALUcontrol  = 4'b0000;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        Branch      = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        pc_en_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read_s = 1'b1;
                ALUSrcB    = 2'b01;
                ALUcontrol = ALU_ADD;
                ir_write_s = mem_ready;
                pc_en_s    = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUcontrol = ALU_ADD;
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUcontrol = ALU_ADD;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                IorD       = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s = 1'b1;
                MemtoReg    = 1'b1;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                IorD        = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUcontrol = dec_alu_s;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                RegDst      = 1'b1;
            end
            S_BRANCH: begin
                Branch     = 1'b1;
                ALUSrcA    = 1'b1;
                ALUcontrol = ALU_SUB;
                PCSource   = 2'b01;
                pc_en_s    = zero;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                pc_en_s  = 1'b1;
            end
            S_TRAP:  ALUcontrol = 4'b0000;
            default: ALUcontrol = 4'b0000;
        endcase
    end

    // Access strobes are held off for the whole time rst is high
    assign MemRead     = mem_read_s  & ~rst;
    assign MemWrite    = mem_write_s & ~rst;
    assign IRWrite     = ir_write_s  & ~rst;
    assign RegWrite    = reg_write_s & ~rst;
    assign pc_en       = pc_en_s     & ~rst;
    assign trap        = trap_r;
    assign instr_count = instr_count_r;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum cycles spent waiting on mem_ready before timeout trap.
REQ-002 Parameter CNT_W, default 32: width of retired-instruction counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  async active-high reset.
REQ-004 opcode  in  6  instruction bits [31:26] from instruction register.
REQ-005 funct  in  6  instruction bits [5:0].
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory completes current read/write this cycle.
REQ-008 ALUcontrol  out  4  0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 slt.
REQ-009 ALUSrcA  out  1  0 = PC, 1 = register A.
REQ-010 ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-011 PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 IorD, RegDst, MemtoReg  out  1 each  datapath mux selects.
REQ-013 MemRead, MemWrite, IRWrite, RegWrite  out  1 each  write/access strobes.
REQ-014 Branch  out  1  BRANCH state active; pc_en  out  1  PC load enable.
REQ-015 trap  out  1  sticky illegal-opcode/funct or memory-timeout flag.
REQ-016 instr_count  out  CNT_W  retired-instruction count.

Function
REQ-017 Moore FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, TRAP.
REQ-018 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUcontrol=0010, PCSource=00; IRWrite and pc_en asserted only in the cycle mem_ready=1, then -> DECODE; else stay.
REQ-019 DECODE: ALUSrcA=0, ALUSrcB=11, ALUcontrol=0010; opcode 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, other -> TRAP.
REQ-020 MEMADR: ALUSrcA=1, ALUSrcB=10, add; LW -> MEMRD, SW -> MEMWR.
REQ-021 MEMRD: MemRead=1, IorD=1; on mem_ready -> MEMWB. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
REQ-022 MEMWR: MemWrite=1, IorD=1; on mem_ready -> FETCH.
REQ-023 EXEC: ALUSrcA=1, ALUSrcB=00, ALUcontrol from funct (100100 AND, 100101 OR, 100000 add, 100010 sub, 101010 slt); unknown funct -> TRAP, else -> ALUWB.
REQ-024 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
REQ-025 BRANCH: Branch=1, ALUSrcA=1, ALUSrcB=00, sub, PCSource=01, pc_en=zero -> FETCH. JUMP: PCSource=10, pc_en=1 -> FETCH.
REQ-026 Wait counter resets on entry to FETCH/MEMRD/MEMWR, increments each cycle mem_ready=0; reaching WAIT_MAX -> TRAP; mem_ready in the same cycle wins.
REQ-027 TRAP: trap=1, all strobes and pc_en 0, state held until rst.
REQ-028 instr_count increments by 1 on the cycle leaving MEMWB, MEMWR, ALUWB, BRANCH or JUMP; wraps modulo 2^CNT_W.
REQ-029 Signals not listed for a state SHALL be 0.

Reset
REQ-030 rst asserted: state=FETCH, wait counter=0, instr_count=0, trap=0; MemRead, MemWrite, IRWrite, RegWrite, pc_en forced 0 while rst high; mid-instruction reset abandons instruction without counting it.

Structure
REQ-031 Shared package ctrl_pkg: state enum, opcode, funct and ALUcontrol constants; sub-module alu_decoder maps funct to ALUcontrol and illegal flag.

Verification
REQ-032 ADD (op 000000, funct 100000), mem_ready=1 in FETCH -> FETCH,DECODE,EXEC,ALUWB; ALUcontrol=0010 in EXEC; RegWrite=1,RegDst=1 in ALUWB; instr_count 0->1.
REQ-033 LW with mem_ready delayed 3 cycles in MEMRD -> MemRead=1,IorD=1 held 4 cycles, MEMWB RegWrite=1,MemtoReg=1; 5 states plus 3 waits = 8 cycles.
REQ-034 BEQ zero=1 -> pc_en=1,PCSource=01 in BRANCH; zero=0 -> pc_en=0; both increment instr_count.
REQ-035 opcode 111111 -> TRAP after DECODE, trap=1, no strobes for 20 cycles; rst pulse -> FETCH, trap=0, instr_count=0.
REQ-036 mem_ready held 0 in FETCH -> TRAP after 15 cycles; mem_ready=1 on 15th waiting cycle -> DECODE, no trap.
